// File: rtl/mem_wait_ctrl.sv
// Memory wait-state controller: stalls the CPU per address region and
// issues a single synchronous memory strobe per access.
module mem_wait_ctrl #(
    parameter logic [15:0] ROM_BASE = 16'hE000,
    parameter logic [7:0]  IO_PAGE  = 8'hD0,
    parameter logic [2:0]  ROM_WS   = 3'd2,
    parameter logic [2:0]  IO_WS    = 3'd3,
    parameter logic [2:0]  RAM_WS   = 3'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_ab,
    input  logic [7:0]  cpu_do,
    input  logic        cpu_we,
    output logic [7:0]  cpu_di,
    output logic        cpu_rdy,
    input  logic        ext_hold,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        stall_clr,
    output logic [15:0] stall_cnt,
    output logic        addr_err
);

    typedef enum logic {
        S_RUN,
        S_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic        rd_v_q, rd_v_d;
    logic [7:0]  di_hold_q, di_hold_d;
    logic [15:0] stall_q, stall_d;
    logic        err_q, err_d;
    logic [2:0]  ws;
    logic        rdy, en;

    // IO page is checked first so it overrides a ROM overlap
    always_comb begin
        ws = RAM_WS;
        if (cpu_ab[15:8] == IO_PAGE) begin
            ws = IO_WS;
        end else if (cpu_ab >= ROM_BASE) begin
            ws = ROM_WS;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rdy     = 1'b0;
        en      = 1'b0;
        if (!ext_hold) begin
            unique case (state_q)
                S_RUN: begin
                    if (ws == 3'd0) begin
                        rdy = 1'b1;
                        en  = 1'b1;
                    end else begin
                        cnt_d   = ws;
                        addr_d  = cpu_ab;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        rdy     = 1'b1;
                        en      = 1'b1;
                        state_d = S_RUN;
                    end
                end
                default: state_d = S_RUN;
            endcase
        end
    end

    assign cpu_rdy   = rdy & rst_n;
    assign mem_en    = en & rst_n;
    assign mem_we    = mem_en & cpu_we;
    assign mem_addr  = cpu_ab;
    assign mem_wdata = cpu_do;
    assign cpu_di    = rd_v_q ? mem_rdata : di_hold_q;
    assign stall_cnt = stall_q;
    assign addr_err  = err_q;

    always_comb begin
        rd_v_d    = mem_en & ~mem_we;
        di_hold_d = rd_v_q ? mem_rdata : di_hold_q;
        stall_d   = stall_q;
        if (stall_clr) begin
            stall_d = 16'h0000;
        end else if (!cpu_rdy && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
        err_d = err_q | ((state_q == S_WAIT) && (cpu_ab != addr_q));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_RUN;
            cnt_q     <= 3'd0;
            addr_q    <= 16'h0000;
            rd_v_q    <= 1'b0;
            di_hold_q <= 8'h00;
            stall_q   <= 16'h0000;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            rd_v_q    <= rd_v_d;
            di_hold_q <= di_hold_d;
            stall_q   <= stall_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_wait_ctrl.sv
// Bench for mem_wait_ctrl: directed and random accesses checked against
// a transaction-level model of wait counts, strobes, data and stall count.
module tb_mem_wait_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cpu_ab;
    logic [7:0]  cpu_do;
    logic        cpu_we;
    logic [7:0]  cpu_di;
    logic        cpu_rdy;
    logic        ext_hold;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        stall_clr;
    logic [15:0] stall_cnt;
    logic        addr_err;

    always #5 clk = ~clk;

    mem_wait_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpu_ab   (cpu_ab),
        .cpu_do   (cpu_do),
        .cpu_we   (cpu_we),
        .cpu_di   (cpu_di),
        .cpu_rdy  (cpu_rdy),
        .ext_hold (ext_hold),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .stall_clr(stall_clr),
        .stall_cnt(stall_cnt),
        .addr_err (addr_err)
    );

    // Synchronous memory device attached to the controller
    logic [7:0] dev_mem [0:65535];
    always @(posedge clk) begin
        if (mem_en && mem_we) dev_mem[mem_addr] = mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= dev_mem[mem_addr];
    end

    // Reference model state
    logic [7:0] ref_mem [0:65535];
    int         stall_exp;
    logic       err_exp;
    logic [7:0] last_rd;

    int tests = 0;
    int fails = 0;

    function automatic int ws_of(input logic [15:0] a);
        if (a[15:8] == 8'hD0) return 3;
        if (a >= 16'hE000) return 2;
        return 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One CPU access; hs/hl place an ext_hold pulse, clr_at pulses
    // stall_clr, glitch_at flips the address LSB in that cycle.
    task automatic do_access(input logic [15:0] addr, input logic we,
                             input logic [7:0] wd, input int hs,
                             input int hl, input int clr_at,
                             input int glitch_at);
        int exp_low = ws_of(addr) + hl;
        int cyc = 0;
        int low = 0;
        int en_n = 0;
        int we_n = 0;
        bit done = 0;
        bit di_bad = 0;
        bit wd_bad = 0;
        while (!done && cyc < 64) begin
            @(negedge clk);
            cpu_ab    = (cyc == glitch_at) ? (addr ^ 16'h0001) : addr;
            cpu_we    = we;
            cpu_do    = wd;
            ext_hold  = (hs >= 0 && cyc >= hs && cyc < hs + hl);
            stall_clr = (cyc == clr_at);
            #1;
            if (cpu_di !== last_rd) di_bad = 1;
            if (mem_we && mem_wdata !== wd) wd_bad = 1;
            if (clr_at >= 0 && cyc == clr_at + 1)
                check("stall_clr", stall_cnt, 0);
            if (!cpu_rdy) low++;
            if (mem_en) en_n++;
            if (mem_we) we_n++;
            if (cpu_rdy) done = 1;
            cyc++;
        end
        ext_hold  = 1'b0;
        stall_clr = 1'b0;
        check("done", done, 1);
        check("low_cycles", low, exp_low);
        check("strobes", en_n, 1);
        check("wr_strobes", we_n, we);
        check("di_stable", di_bad, 0);
        check("wdata", wd_bad, 0);
        if (clr_at >= 0) stall_exp = exp_low - clr_at - 1;
        else stall_exp += exp_low;
        if (glitch_at >= 1 && glitch_at < ws_of(addr)) err_exp = 1'b1;
        if (we) ref_mem[addr] = wd;
        else last_rd = ref_mem[addr];
        @(posedge clk);
        #1;
        check("stall_cnt", stall_cnt, stall_exp);
        check("addr_err", addr_err, err_exp);
        if (!we) check("rdata", cpu_di, last_rd);
    endtask

    // Release reset while presenting a RAM read of 0x0200
    task automatic release_chk();
        @(negedge clk);
        rst_n     = 1'b1;
        cpu_ab    = 16'h0200;
        cpu_we    = 1'b0;
        ext_hold  = 1'b0;
        stall_clr = 1'b0;
        #1;
        check("rst_rdy", cpu_rdy, 1);
        check("rst_en", mem_en, 1);
        check("rst_di", cpu_di, 8'h00);
        check("rst_stall", stall_cnt, 0);
        check("rst_err", addr_err, 0);
        @(posedge clk);
        #1;
        last_rd   = ref_mem[16'h0200];
        stall_exp = 0;
        err_exp   = 1'b0;
        check("rst_rd", cpu_di, last_rd);
        check("rst_stall2", stall_cnt, 0);
    endtask

    task automatic reset_chk(input int n);
        int wes = 0;
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            if (mem_we) wes++;
            check("in_rst_rdy", cpu_rdy, 0);
            check("in_rst_en", mem_en, 0);
        end
        check("in_rst_we", wes, 0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            dev_mem[i] = 8'(i ^ (i >> 8) ^ 8'h3C);
            ref_mem[i] = 8'(i ^ (i >> 8) ^ 8'h3C);
        end
        dev_mem[16'h0200] = 8'h5A;
        ref_mem[16'h0200] = 8'h5A;
        rst_n     = 1'b0;
        cpu_ab    = 16'h0200;
        cpu_do    = 8'h77;
        cpu_we    = 1'b1;
        ext_hold  = 1'b0;
        stall_clr = 1'b0;
        stall_exp = 0;
        err_exp   = 1'b0;
        last_rd   = 8'h00;

        reset_chk(2);
        release_chk();

        do_access(16'h0200, 1'b0, 8'h00, -1, 0, -1, -1);
        do_access(16'hFFFC, 1'b0, 8'h00, -1, 0, -1, -1);
        do_access(16'hD012, 1'b1, 8'hA5, -1, 0, -1, -1);
        do_access(16'hD012, 1'b0, 8'h00, -1, 0, -1, -1);
        do_access(16'hE010, 1'b0, 8'h00, 1, 4, -1, -1);
        do_access(16'hE044, 1'b0, 8'h00, 2, 3, -1, -1);
        do_access(16'h1234, 1'b1, 8'h9C, 0, 2, -1, -1);
        do_access(16'hD030, 1'b0, 8'h00, -1, 0, 1, -1);

        for (int k = 0; k < 40; k++) begin
            logic [15:0] a;
            int r, w, hs, hl, ca, el;
            r = int'($urandom_range(0, 3));
            case (r)
                0: a = 16'($urandom_range(0, 16'hCFFF));
                1: a = {8'hD0, 8'($urandom)};
                2: a = 16'($urandom_range(16'hE000, 16'hFFFF));
                default: a = 16'($urandom_range(16'hD100, 16'hDFFF));
            endcase
            w  = int'($urandom_range(0, 1));
            hs = -1;
            hl = 0;
            ca = -1;
            if ($urandom_range(0, 2) == 0) begin
                hs = int'($urandom_range(0, ws_of(a)));
                hl = int'($urandom_range(1, 4));
            end
            el = ws_of(a) + hl;
            if (el > 0 && $urandom_range(0, 4) == 0)
                ca = int'($urandom_range(0, el - 1));
            do_access(a, w[0], 8'($urandom), hs, hl, ca, -1);
        end

        do_access(16'hE020, 1'b0, 8'h00, -1, 0, -1, 1);
        do_access(16'h0300, 1'b0, 8'h00, -1, 0, -1, -1);
        do_access(16'hD0F0, 1'b1, 8'h11, -1, 0, -1, 2);
        check("err_sticky", addr_err, 1);

        @(negedge clk);
        cpu_ab = 16'hD012;
        cpu_we = 1'b1;
        cpu_do = 8'h5C;
        #1;
        check("mid_low0", cpu_rdy, 0);
        check("mid_we0", mem_we, 0);
        @(negedge clk);
        #1;
        check("mid_low1", cpu_rdy, 0);
        check("mid_we1", mem_we, 0);
        reset_chk(2);
        release_chk();
        do_access(16'hD012, 1'b0, 8'h00, -1, 0, -1, -1);
        do_access(16'hD030, 1'b1, 8'h42, -1, 0, 0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
